// File: rtl/cam_stream_gen.sv
// rtl/cam_stream_gen.sv - DVP camera-stream generator, RGB444 as two bytes per pixel.
// Optional pixel side-channel (o_pix_valid/o_pix) under `define CAMGEN_PIXOUT_EN.
module cam_stream_gen #(
   parameter int         COLS       = 640,
   parameter int         ROWS       = 480,
   parameter int         VSYNC_LEN  = 3,
   parameter int         VBP_LEN    = 17,
   parameter int         HBLANK_LEN = 6,
   parameter int         VFP_LEN    = 10,
   parameter int         FRAMES     = 0,
   parameter logic [3:0] PAD        = 4'hF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic [1:0]  i_mode,
   input  logic [15:0] i_seed,
   output logic        o_vsync,
   output logic        o_href,
   output logic [7:0]  o_data,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic [15:0] o_frame_cnt
`ifdef CAMGEN_PIXOUT_EN
   ,
   output logic        o_pix_valid,
   output logic [11:0] o_pix
`endif
);
   localparam logic [15:0] COL_LAST = 16'(COLS - 1);
   localparam logic [15:0] ROW_LAST = 16'(ROWS - 1);
   localparam logic [15:0] BAR_LAST = 16'(COLS / 8 - 1);
   localparam logic [15:0] VS_LAST  = 16'(VSYNC_LEN - 1);
   localparam logic [15:0] VBP_LAST = 16'(VBP_LEN - 1);
   localparam logic [15:0] HB_LAST  = 16'(HBLANK_LEN - 1);
   localparam logic [15:0] VFP_LAST = 16'(VFP_LEN - 1);
   localparam logic [15:0] VFP_PRE  = 16'(VFP_LEN - 2);
   localparam logic [15:0] FRAMES_W = 16'(FRAMES);
   localparam bit          FRAMES_EN = (FRAMES != 0);

   typedef enum logic [2:0] {
      S_IDLE, S_VSYNC, S_VBP, S_PIX_HI, S_PIX_LO, S_HBLANK, S_VFP
   } state_t;

   state_t      r_state;
   logic [15:0] r_cnt, r_col, r_row, r_bar_pos, r_lfsr, r_frame_cnt;
   logic [11:0] r_seed, r_pix;
   logic [2:0]  r_bar;
   logic [1:0]  r_mode;
   logic        r_stop, r_vsync, r_href, r_busy, r_done;
   logic [7:0]  r_data;
`ifdef CAMGEN_PIXOUT_EN
   logic        r_pix_valid;
   logic [11:0] r_pix_out;
`endif

   logic [15:0] w_lfsr_step, w_seed_lfsr;
   logic        w_bar_wrap, w_frame_end, w_enter;
   logic [2:0]  w_bar_nxt;
   logic [11:0] w_pix_first, w_pix_row_nxt, w_pix_col_nxt;

   function automatic logic [11:0] f_pix(input logic [1:0] mode, input logic [11:0] seed,
                                         input logic [2:0] bar, input logic [11:0] ramp,
                                         input logic [11:0] lfsr);
      logic [11:0] bar_rgb;
      case (bar)
         3'd0:    bar_rgb = 12'hFFF;
         3'd1:    bar_rgb = 12'hFF0;
         3'd2:    bar_rgb = 12'h0FF;
         3'd3:    bar_rgb = 12'h0F0;
         3'd4:    bar_rgb = 12'hF0F;
         3'd5:    bar_rgb = 12'hF00;
         3'd6:    bar_rgb = 12'h00F;
         default: bar_rgb = 12'h000;
      endcase
      case (mode)
         2'd0:    f_pix = bar_rgb;
         2'd1:    f_pix = ramp;
         2'd2:    f_pix = lfsr;
         default: f_pix = seed;
      endcase
   endfunction

   assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   assign w_seed_lfsr = (i_seed == 16'h0000) ? 16'h0001 : i_seed;
   assign w_bar_wrap  = (r_bar_pos == BAR_LAST);
   assign w_bar_nxt   = w_bar_wrap ? r_bar + 3'd1 : r_bar;
   assign w_frame_end = r_stop || (FRAMES_EN && (r_frame_cnt == FRAMES_W));
   assign w_enter     = ((r_state == S_IDLE) && i_start) ||
                        ((r_state == S_VFP) && (r_cnt == VFP_LAST) && !w_frame_end);

   // Next-pixel lookahead so that o_data can be registered on the state transition.
   assign w_pix_first   = f_pix(r_mode, r_seed, 3'd0, r_frame_cnt[11:0], r_lfsr[11:0]);
   assign w_pix_row_nxt = f_pix(r_mode, r_seed, 3'd0,
                                r_row[11:0] + 12'd1 + r_frame_cnt[11:0], r_lfsr[11:0]);
   assign w_pix_col_nxt = f_pix(r_mode, r_seed, w_bar_nxt,
                                r_col[11:0] + 12'd1 + r_row[11:0] + r_frame_cnt[11:0],
                                w_lfsr_step[11:0]);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_bar_pos   <= '0;
         r_bar       <= '0;
         r_lfsr      <= 16'h0001;
         r_frame_cnt <= '0;
         r_seed      <= '0;
         r_mode      <= '0;
         r_pix       <= '0;
         r_stop      <= 1'b0;
         r_vsync     <= 1'b0;
         r_href      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_data      <= '0;
`ifdef CAMGEN_PIXOUT_EN
         r_pix_valid <= 1'b0;
         r_pix_out   <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         if (i_stop) r_stop <= 1'b1;
         case (r_state)
            S_IDLE: if (i_start) r_frame_cnt <= '0;
            S_VSYNC: begin
               if (r_cnt == VS_LAST) begin
                  r_state <= S_VBP;
                  r_vsync <= 1'b0;
                  r_cnt   <= '0;
               end else r_cnt <= r_cnt + 16'd1;
            end
            S_VBP: begin
               if (r_cnt == VBP_LAST) begin
                  r_state   <= S_PIX_HI;
                  r_href    <= 1'b1;
                  r_data    <= {PAD, w_pix_first[11:8]};
                  r_pix     <= w_pix_first;
                  r_col     <= '0;
                  r_row     <= '0;
                  r_bar     <= '0;
                  r_bar_pos <= '0;
               end else r_cnt <= r_cnt + 16'd1;
            end
            S_PIX_HI: begin
               r_state <= S_PIX_LO;
               r_data  <= r_pix[7:0];
`ifdef CAMGEN_PIXOUT_EN
               r_pix_valid <= 1'b1;
               r_pix_out   <= r_pix;
`endif
            end
            S_PIX_LO: begin
               r_lfsr <= w_lfsr_step;
`ifdef CAMGEN_PIXOUT_EN
               r_pix_valid <= 1'b0;
`endif
               if (r_col == COL_LAST) begin
                  r_state <= S_HBLANK;
                  r_href  <= 1'b0;
                  r_data  <= '0;
                  r_cnt   <= '0;
               end else begin
                  r_state   <= S_PIX_HI;
                  r_col     <= r_col + 16'd1;
                  r_bar_pos <= w_bar_wrap ? 16'd0 : r_bar_pos + 16'd1;
                  r_bar     <= w_bar_nxt;
                  r_data    <= {PAD, w_pix_col_nxt[11:8]};
                  r_pix     <= w_pix_col_nxt;
               end
            end
            S_HBLANK: begin
               if (r_cnt == HB_LAST) begin
                  r_cnt <= '0;
                  if (r_row == ROW_LAST) begin
                     r_state <= S_VFP;
                     if (VFP_LEN == 1) begin
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                     end
                  end else begin
                     r_state   <= S_PIX_HI;
                     r_href    <= 1'b1;
                     r_row     <= r_row + 16'd1;
                     r_col     <= '0;
                     r_bar     <= '0;
                     r_bar_pos <= '0;
                     r_data    <= {PAD, w_pix_row_nxt[11:8]};
                     r_pix     <= w_pix_row_nxt;
                  end
               end else r_cnt <= r_cnt + 16'd1;
            end
            S_VFP: begin
               if (r_cnt == VFP_LAST) begin
                  if (w_frame_end) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_stop  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
                  // Done pulse and count land together on the final VFP cycle.
                  if (r_cnt == VFP_PRE) begin
                     r_done      <= 1'b1;
                     r_frame_cnt <= r_frame_cnt + 16'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_enter) begin
            r_state <= S_VSYNC;
            r_vsync <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_mode  <= i_mode;
            r_seed  <= i_seed[11:0];
            r_lfsr  <= w_seed_lfsr;
         end
      end
   end

   assign o_vsync      = r_vsync;
   assign o_href       = r_href;
   assign o_data       = r_data;
   assign o_busy       = r_busy;
   assign o_frame_done = r_done;
   assign o_frame_cnt  = r_frame_cnt;
`ifdef CAMGEN_PIXOUT_EN
   assign o_pix_valid  = r_pix_valid;
   assign o_pix        = r_pix_out;
`endif
endmodule

// File: tb/tb_cam_stream_gen.sv
// tb/tb_cam_stream_gen.sv - self-checking bench for cam_stream_gen.
// Two instances: A (8x2, FRAMES=1) and B (16x2, free-running); optional CAMGEN_PIXOUT_EN ports wired.
`timescale 1ns/1ps
module tb_cam_stream_gen;
   localparam int VS = 3, VBP = 17, HB = 6, VFP = 10;
   localparam int A_COLS = 8, B_COLS = 16, ROWS = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_start, a_stop, b_rst, b_start, b_stop;
   logic [1:0]  a_mode, b_mode;
   logic [15:0] a_seed, b_seed;
   logic        a_vs, a_href, a_busy, a_done, b_vs, b_href, b_busy, b_done;
   logic [7:0]  a_data, b_data;
   logic [15:0] a_cnt, b_cnt;
`ifdef CAMGEN_PIXOUT_EN
   logic        a_pv, b_pv;
   logic [11:0] a_pix, b_pix;
`endif

   cam_stream_gen #(.COLS(A_COLS), .ROWS(ROWS), .FRAMES(1)) u_a (
      .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .i_stop(a_stop),
      .i_mode(a_mode), .i_seed(a_seed), .o_vsync(a_vs), .o_href(a_href),
      .o_data(a_data), .o_busy(a_busy), .o_frame_done(a_done), .o_frame_cnt(a_cnt)
`ifdef CAMGEN_PIXOUT_EN
      , .o_pix_valid(a_pv), .o_pix(a_pix)
`endif
   );

   cam_stream_gen #(.COLS(B_COLS), .ROWS(ROWS), .FRAMES(0)) u_b (
      .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_stop(b_stop),
      .i_mode(b_mode), .i_seed(b_seed), .o_vsync(b_vs), .o_href(b_href),
      .o_data(b_data), .o_busy(b_busy), .o_frame_done(b_done), .o_frame_cnt(b_cnt)
`ifdef CAMGEN_PIXOUT_EN
      , .o_pix_valid(b_pv), .o_pix(b_pix)
`endif
   );

   logic        sel;
   logic        m_vs, m_href, m_busy, m_done;
   logic [7:0]  m_data;
   logic [15:0] m_cnt;
   assign m_vs   = sel ? b_vs   : a_vs;
   assign m_href = sel ? b_href : a_href;
   assign m_busy = sel ? b_busy : a_busy;
   assign m_done = sel ? b_done : a_done;
   assign m_data = sel ? b_data : a_data;
   assign m_cnt  = sel ? b_cnt  : a_cnt;

   int          n_tests = 0, n_fail = 0;
   int          cur_mode;
   logic [15:0] cur_seed;
   logic [15:0] lfsr_tab [64];
   logic [7:0]  cap [128];
   int          ncap, mm_t;
   logic [11:0] mm_act, mm_exp;
   int          errs, nbusy, ndone, fl;

   typedef struct {
      int          mode;
      logic [15:0] seed;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [11:0] p1;
      int          busy;
   } vec_t;
   vec_t        tbl [4];
   logic [15:0] bar_pairs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic chk_stream(input string name, input int bad);
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s: %0d bad cycles, first t=%0d {vs,href,data,busy,done} got %h want %h; want 0 bad",
                  name, bad, mm_t, mm_act, mm_exp);
      end
   endtask

   function automatic int cols();
      return sel ? B_COLS : A_COLS;
   endfunction

   function automatic int frame_len();
      return VS + VBP + ROWS * (2 * cols() + HB) + VFP;
   endfunction

   task automatic build_lfsr(input logic [15:0] seed);
      logic [15:0] x;
      x = (seed == 16'h0000) ? 16'h0001 : seed;
      for (int n = 0; n < 64; n++) begin
         lfsr_tab[n] = x;
         x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
      end
   endtask

   function automatic logic [11:0] model_pix(input int mode, input logic [15:0] seed,
                                             input int c, input int r, input int f);
      logic [11:0] bars [8];
      logic [15:0] lv;
      bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
      case (mode)
         0: return bars[c / (cols() / 8)];
         1: return 12'((c + r + f) % 4096);
         2: begin
            lv = lfsr_tab[r * cols() + c];
            return lv[11:0];
         end
         default: return seed[11:0];
      endcase
   endfunction

   task automatic drv(input logic start, input logic stop);
      if (sel) begin b_start = start; b_stop = stop; end
      else     begin a_start = start; a_stop = stop; end
   endtask

   task automatic drv_cfg(input logic [1:0] m, input logic [15:0] s);
      if (sel) begin b_mode = m; b_seed = s; end
      else     begin a_mode = m; a_seed = s; end
   endtask

   // Called at a negedge; returns at the negedge of the first frame cycle.
   task automatic start_frame(input int mode, input logic [15:0] seed, input logic with_stop);
      cur_mode = mode;
      cur_seed = seed;
      drv_cfg(2'(mode), seed);
      drv(1'b1, with_stop);
      @(negedge clk);
      drv(1'b0, 1'b0);
   endtask

   task automatic check_frame(input int f, input int nt, input int stop_at, input int start_at,
                              output int bad, output int nb, output int nd);
      int          flen, rowlen, u, r, k, c;
      logic        ev, eh, edone;
      logic [7:0]  ed;
      logic [11:0] p;
      flen = frame_len();
      rowlen = 2 * cols() + HB;
      bad = 0; nb = 0; nd = 0; ncap = 0; mm_t = -1;
      build_lfsr(cur_seed);
      for (int t = 0; t < nt; t++) begin
         ev = 1'b0; eh = 1'b0; ed = 8'h00; edone = (t == flen - 1);
         if (t < VS) ev = 1'b1;
         else if (t >= VS + VBP && t < VS + VBP + ROWS * rowlen) begin
            u = t - VS - VBP;
            r = u / rowlen;
            k = u % rowlen;
            if (k < 2 * cols()) begin
               eh = 1'b1;
               c = k / 2;
               p = model_pix(cur_mode, cur_seed, c, r, f);
               ed = (k % 2 == 0) ? {4'hF, p[11:8]} : p[7:0];
            end
         end
         if (m_busy) nb++;
         if (m_done) nd++;
         if (m_href && ncap < 128) begin cap[ncap] = m_data; ncap++; end
         if ({m_vs, m_href, m_data, m_busy, m_done} !== {ev, eh, ed, 1'b1, edone}) begin
            if (bad == 0) begin
               mm_t = t;
               mm_act = {m_vs, m_href, m_data, m_busy, m_done};
               mm_exp = {ev, eh, ed, 1'b1, edone};
            end
            bad++;
         end
         drv(t == start_at, t == stop_at);
         if (t == 2) drv_cfg(2'($urandom), 16'($urandom));
         if (t == flen - 3) drv_cfg(2'(cur_mode), cur_seed);
         @(negedge clk);
      end
      drv(1'b0, 1'b0);
   endtask

   initial begin
      tbl[0] = '{3, 16'h0ABC, 8'hFA, 8'hBC, 12'hABC, 74};
      tbl[1] = '{2, 16'h0000, 8'hF0, 8'h01, 12'h400, 74};
      tbl[2] = '{0, 16'h5555, 8'hFF, 8'hFF, 12'hFF0, 74};
      tbl[3] = '{1, 16'h0000, 8'hF0, 8'h00, 12'h001, 74};
      bar_pairs = '{16'hFFFF, 16'hFFF0, 16'hF0FF, 16'hF0F0, 16'hFF0F, 16'hFF00, 16'hF00F, 16'hF000};

      sel = 1'b0;
      a_rst = 1'b1; b_rst = 1'b1;
      a_start = 1'b0; a_stop = 1'b0; a_mode = 2'd0; a_seed = 16'h0;
      b_start = 1'b0; b_stop = 1'b0; b_mode = 2'd0; b_seed = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_state_a", 32'({a_vs, a_href, a_data, a_busy, a_done, a_cnt}), 32'h0);
      chk("rst_state_b", 32'({b_vs, b_href, b_data, b_busy, b_done, b_cnt}), 32'h0);
      a_rst = 1'b0; b_rst = 1'b0;
      @(negedge clk);

      // Table-driven single frames on A.
      for (int i = 0; i < 4; i++) begin
         start_frame(tbl[i].mode, tbl[i].seed, 1'b0);
         chk("cnt_at_start", 32'(m_cnt), 32'h0);
         check_frame(0, frame_len(), -1, -1, errs, nbusy, ndone);
         chk_stream("stream_tbl", errs);
         chk("busy_cycles", 32'(nbusy), 32'(tbl[i].busy));
         chk("done_pulses", 32'(ndone), 32'd1);
         chk("href_bytes", 32'(ncap), 32'(2 * ROWS * A_COLS));
         chk("byte0", 32'(cap[0]), 32'(tbl[i].b0));
         chk("byte1", 32'(cap[1]), 32'(tbl[i].b1));
         chk("pix1", 32'({cap[2][3:0], cap[3]}), 32'(tbl[i].p1));
         chk("idle_after", 32'({m_busy, m_vs, m_href}), 32'h0);
         chk("cnt_end", 32'(m_cnt), 32'd1);
      end

      // Randomized frames on A against the model.
      for (int i = 0; i < 6; i++) begin
         start_frame(int'($urandom_range(0, 3)), (i == 0) ? 16'h0000 : 16'($urandom), 1'b0);
         check_frame(0, frame_len(), -1, -1, errs, nbusy, ndone);
         chk_stream("stream_rand", errs);
         chk("rand_idle_cnt", 32'({m_busy, m_cnt}), 32'h1);
      end

      // B: ramp, free running, stop mid frame 2.
      sel = 1'b1;
      fl = frame_len();
      start_frame(1, 16'($urandom), 1'b0);
      chk("ramp_cnt0", 32'(m_cnt), 32'h0);
      check_frame(0, fl, -1, -1, errs, nbusy, ndone);
      chk_stream("ramp_f0", errs);
      chk("ramp_cnt1", 32'(m_cnt), 32'd1);
      check_frame(1, fl, -1, -1, errs, nbusy, ndone);
      chk_stream("ramp_f1", errs);
      chk("ramp_cnt2", 32'(m_cnt), 32'd2);
      check_frame(2, fl, fl / 2, -1, errs, nbusy, ndone);
      chk_stream("ramp_f2", errs);
      chk("ramp_pix00_f2", 32'({cap[0][3:0], cap[1]}), 32'h002);
      chk("ramp_done_f2", 32'(ndone), 32'd1);
      chk("ramp_idle", 32'(m_busy), 32'h0);
      chk("ramp_cnt3", 32'(m_cnt), 32'd3);

      // B: colour bars, start+stop together, start while busy ignored.
      start_frame(0, 16'($urandom), 1'b1);
      check_frame(0, fl, -1, 40, errs, nbusy, ndone);
      chk_stream("bars_stream", errs);
      chk("bars_done", 32'(ndone), 32'd1);
      chk("bars_idle_cnt", 32'({m_busy, m_cnt}), 32'h1);
      for (int k = 0; k < 8; k++)
         chk("bar_bytes", 32'({cap[4*k], cap[4*k+1], cap[4*k+2], cap[4*k+3]}),
             {bar_pairs[k], bar_pairs[k]});
      repeat (5) @(negedge clk);
      chk("no_restart", 32'({m_busy, m_vs, m_href}), 32'h0);

      // B: asynchronous reset during PIX_LO of row 1, then a clean frame.
      start_frame(2, 16'($urandom), 1'b0);
      check_frame(0, fl, -1, -1, errs, nbusy, ndone);
      chk_stream("pre_rst_f0", errs);
      check_frame(1, VS + VBP + (2 * B_COLS + HB) + 1, -1, -1, errs, nbusy, ndone);
      chk_stream("pre_rst_f1", errs);
      chk("pre_rst_href", 32'({m_href, m_cnt}), 32'h10001);
      b_rst = 1'b1;
      #1;
      chk("rst_async", 32'({b_vs, b_href, b_data, b_busy, b_done, b_cnt}), 32'h0);
      @(negedge clk);
      b_rst = 1'b0;
      @(negedge clk);
      start_frame(2, 16'h0000, 1'b1);
      chk("post_rst_cnt0", 32'(m_cnt), 32'h0);
      check_frame(0, fl, -1, -1, errs, nbusy, ndone);
      chk_stream("post_rst_frame", errs);
      chk("post_rst_idle_cnt", 32'({m_busy, m_cnt}), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
